fir_xifu_scoreboard: RTL and testbench
======================================

# fir_xifu_scoreboard

Parametrised per-ID instruction scoreboard for the FIR XIF unit, tracking each offloaded instruction from issue through commit or kill to writeback release. It sits between the CV-XIF issue/commit channels and the writeback stage: it filters duplicate commits, bounds outstanding instructions, gates issue acceptance and flags protocol violations. It supersedes the flat commit/kill bit-vectors with a per-ID state machine and an outstanding counter.

## Interface
- N_ID, default 16: number of tracked transaction IDs; legal range 2..16.
- ID_W, default $clog2(N_ID): ID field width; derived, not overridden.
- MAX_OUT, default 4: maximum simultaneously outstanding instructions; legal range 1..N_ID.
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, asynchronous, active-low.
- issue_valid_i  in  1  XIF issue valid.
- issue_id_i  in  ID_W  XIF issue ID.
- issue_accept_i  in  1  decoder accepts the instruction; from decode, not from this block.
- issue_ready_o  out  1  scoreboard can take issue_id_i; combinational.
- commit_valid_i  in  1  XIF commit valid.
- commit_id_i  in  ID_W  XIF commit ID.
- commit_kill_i  in  1  XIF commit_kill.
- clear_i  in  N_ID  one-hot-per-ID release from writeback.
- commit_o  out  N_ID  ID is COMMITTED; registered.
- kill_o  out  N_ID  ID is KILLED; registered.
- busy_o  out  N_ID  ID is not FREE; registered.
- outstanding_o  out  $clog2(MAX_OUT+1)  non-FREE ID count; registered.
- err_o  out  1  sticky protocol error; registered.

## Operation
- Per-ID FSM states: FREE, ISSUED, COMMITTED, KILLED. Reset: all FREE.
- Issue event: issue_valid_i & issue_accept_i & issue_ready_o. FREE -> ISSUED.
- issue_ready_o = (outstanding_q < MAX_OUT) & (state[issue_id_i] == FREE). A same-cycle clear does not raise it.
- Commit event: commit_valid_i on an ID in ISSUED. ISSUED -> COMMITTED if !commit_kill_i, otherwise -> KILLED.
- Commit on an ID not in ISSUED is ignored. This covers duplicate commits for one ID, whether back-to-back or repeated later.
- Commit in the same cycle as the issue of the same ID: FREE -> COMMITTED/KILLED directly.
- clear_i[k] releases COMMITTED or KILLED -> FREE. clear_i[k] in FREE or ISSUED is ignored.
- Clear and issue of the same ID in one cycle cannot occur: issue requires FREE, and clear acts only on resolved IDs.
- Outstanding counter:
  - +1 on issue event; -1 per cleared resolved ID (several clears may land in one cycle).
  - Net update is applied in one step; never wraps.
- Illegal events:
  - commit to an ID in FREE with no same-cycle issue;
  - commit to an ID in COMMITTED or KILLED;
  - clear of an ID in FREE or ISSUED;
  - issue_valid_i & issue_accept_i while issue_ready_o is low.

## Timing
- Reset values: commit_o, kill_o, busy_o = 0; outstanding_o = 0; err_o = 0.
- issue_ready_o reflects registered state; combinational only from issue_id_i.
- commit_o, kill_o, busy_o and outstanding_o update the cycle after the triggering event: 1-cycle latency.
- Reset asserted mid-operation: all IDs return to FREE immediately; err_o clears.

## Configuration
- FIR_XIFU_SB_ERR_EN defined: illegal events set err_o, which is sticky until reset. Illegal events are also still ignored for state purposes.
- FIR_XIFU_SB_ERR_EN undefined: no detection logic is compiled; err_o is tied 0 and illegal events are silently ignored.

## Structure
- fir_xifu_pkg holds:
  - sb_state_e, the 2-bit enum FREE/ISSUED/COMMITTED/KILLED;
  - default constants SB_N_ID and SB_MAX_OUT.
- Sub-module fir_xifu_sb_entry: one per ID, generated N_ID times.
  - Inputs: issue_hit, commit_hit, kill, clear.
  - Outputs: state, illegal.
- The top level holds issue_ready, the outstanding counter and the error OR-reduction.

## Test plan
- Basic flow: issue ID 3, commit ID 3 (kill=0) the next cycle -> commit_o[3]=1 one cycle later, outstanding_o=1. Then clear_i[3] -> busy_o[3]=0, outstanding_o=0.
- Duplicate commit: commit ID 5 in three consecutive cycles after its issue -> state COMMITTED once, outstanding_o unchanged, err_o=1 only with ERR_EN.
- Kill: issue ID 2, commit ID 2 with kill=1 -> kill_o[2]=1, commit_o[2]=0; clear_i[2] -> FREE.
- Full: MAX_OUT=4, issue IDs 0..3 -> issue_ready_o=0 for ID 4. In the same cycle, clear ID 1 (resolved) -> issue_ready_o=1 next cycle, outstanding_o=3.
- Same-cycle issue+commit of ID 7 -> commit_o[7]=1 next cycle, outstanding_o=1, err_o=0.
- Reset asserted with 3 IDs outstanding -> all outputs 0 asynchronously; ID 0 issue accepted in the first cycle after release.

Source files
------------

// File: rtl/fir_xifu_pkg.sv
// fir_xifu_pkg: shared types and default sizing for the FIR XIF unit scoreboard.
// Holds the per-ID lifecycle enum and the default ID count / outstanding limit.
package fir_xifu_pkg;

    // Lifecycle of one offloaded instruction ID.
    typedef enum logic [1:0] {
        FREE      = 2'd0,
        ISSUED    = 2'd1,
        COMMITTED = 2'd2,
        KILLED    = 2'd3
    } sb_state_e;

    localparam int SB_N_ID    = 16;
    localparam int SB_MAX_OUT = 4;

    // True once the commit channel has decided the fate of an ID.
    function automatic logic sb_is_resolved(sb_state_e s);
        return (s == COMMITTED) || (s == KILLED);
    endfunction

endpackage

// File: rtl/fir_xifu_sb_entry.sv
// fir_xifu_sb_entry: lifecycle FSM for a single transaction ID.
// Illegal-event detection is only compiled when FIR_XIFU_SB_ERR_EN is defined;
// otherwise illegal is tied low and illegal events are silently ignored.
module fir_xifu_sb_entry
    import fir_xifu_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      issue_hit,
    input  logic      commit_hit,
    input  logic      kill,
    input  logic      clear,
    output sb_state_e state,
    output logic      illegal
);

    sb_state_e state_q;
    sb_state_e state_d;

    // State register; reset returns the ID to FREE immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a commit landing with its own issue resolves the ID directly.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FREE: begin
                if (issue_hit) begin
                    if (commit_hit) begin
                        state_d = kill ? KILLED : COMMITTED;
                    end else begin
                        state_d = ISSUED;
                    end
                end
            end
            ISSUED: begin
                if (commit_hit) begin
                    state_d = kill ? KILLED : COMMITTED;
                end
            end
            COMMITTED, KILLED: begin
                if (clear) begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

`ifdef FIR_XIFU_SB_ERR_EN
    // Flag events that are ignored because they do not fit the current state.
    always_comb begin
        illegal = 1'b0;
        unique case (state_q)
            FREE:              illegal = (commit_hit & ~issue_hit) | clear;
            ISSUED:            illegal = clear;
            COMMITTED, KILLED: illegal = commit_hit;
            default:           illegal = 1'b0;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

    assign state = state_q;

endmodule

// File: rtl/fir_xifu_scoreboard.sv
// fir_xifu_scoreboard: per-ID instruction scoreboard between the CV-XIF
// issue/commit channels and writeback. Gates issue acceptance, drops duplicate
// commits, bounds the number of outstanding IDs and flags protocol violations.
// Optional feature: define FIR_XIFU_SB_ERR_EN to build the sticky err_o logic;
// without it err_o is tied 0.
module fir_xifu_scoreboard
    import fir_xifu_pkg::*;
#(
    parameter  int N_ID    = SB_N_ID,
    parameter  int MAX_OUT = SB_MAX_OUT,
    localparam int ID_W    = $clog2(N_ID),
    localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             issue_valid_i,
    input  logic [ID_W-1:0]  issue_id_i,
    input  logic             issue_accept_i,
    output logic             issue_ready_o,
    input  logic             commit_valid_i,
    input  logic [ID_W-1:0]  commit_id_i,
    input  logic             commit_kill_i,
    input  logic [N_ID-1:0]  clear_i,
    output logic [N_ID-1:0]  commit_o,
    output logic [N_ID-1:0]  kill_o,
    output logic [N_ID-1:0]  busy_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             err_o
);

    // Wide enough to hold count + 1 issue and all N_ID clears without overflow.
    localparam int SUM_W = $clog2(N_ID + MAX_OUT + 2);

    sb_state_e        state_vec [N_ID];
    logic [N_ID-1:0]  free_vec;
    logic [N_ID-1:0]  resolved_vec;
    logic [N_ID-1:0]  illegal_vec;
    logic [CNT_W-1:0] outstanding_q;
    logic [CNT_W-1:0] outstanding_d;
    logic             id_in_range;
    logic             issue_fire;

    // Per-ID status decoded from the entry state registers.
    always_comb begin
        free_vec     = '0;
        resolved_vec = '0;
        commit_o     = '0;
        kill_o       = '0;
        busy_o       = '0;
        for (int i = 0; i < N_ID; i++) begin
            free_vec[i]     = (state_vec[i] == FREE);
            resolved_vec[i] = sb_is_resolved(state_vec[i]);
            commit_o[i]     = (state_vec[i] == COMMITTED);
            kill_o[i]       = (state_vec[i] == KILLED);
            busy_o[i]       = (state_vec[i] != FREE);
        end
    end

    // Ready looks only at registered state, so a same-cycle clear cannot raise it.
    always_comb begin
        id_in_range   = (int'(issue_id_i) < N_ID);
        issue_ready_o = id_in_range
                        && (outstanding_q < CNT_W'(MAX_OUT))
                        && free_vec[issue_id_i];
    end

    assign issue_fire = issue_valid_i & issue_accept_i & issue_ready_o;

    for (genvar k = 0; k < N_ID; k++) begin : g_entry
        fir_xifu_sb_entry u_entry (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .issue_hit  (issue_fire && (issue_id_i == ID_W'(k))),
            .commit_hit (commit_valid_i && (commit_id_i == ID_W'(k))),
            .kill       (commit_kill_i),
            .clear      (clear_i[k]),
            .state      (state_vec[k]),
            .illegal    (illegal_vec[k])
        );
    end

    // Net counter update: +1 per issue, -1 per resolved ID released this cycle.
    always_comb begin
        logic [SUM_W-1:0] clr_cnt;
        logic [SUM_W-1:0] up_sum;
        logic [SUM_W-1:0] net;
        clr_cnt = '0;
        for (int i = 0; i < N_ID; i++) begin
            clr_cnt = clr_cnt + SUM_W'(clear_i[i] & resolved_vec[i]);
        end
        up_sum = SUM_W'(outstanding_q) + SUM_W'(issue_fire);
        if (up_sum < clr_cnt) begin
            net = '0;
        end else begin
            net = up_sum - clr_cnt;
        end
        if (net > SUM_W'(MAX_OUT)) begin
            net = SUM_W'(MAX_OUT);
        end
        outstanding_d = CNT_W'(net);
    end

    // Outstanding count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

    assign outstanding_o = outstanding_q;

`ifdef FIR_XIFU_SB_ERR_EN
    logic err_q;
    logic issue_violation;

    assign issue_violation = issue_valid_i & issue_accept_i & ~issue_ready_o;

    // Sticky error: any illegal per-ID event or an accept while not ready.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (|illegal_vec) | issue_violation;
        end
    end

    assign err_o = err_q;
`else
    logic unused_illegal;

    assign unused_illegal = |illegal_vec;
    assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_fir_xifu_scoreboard.sv
// tb_fir_xifu_scoreboard: scoreboard-style bench. The driver updates a
// set-based reference model and queues expected responses; two monitors pop
// and compare issue_ready_o (same cycle) and the registered outputs (next cycle).
module tb_fir_xifu_scoreboard;

    localparam int N_ID    = 16;
    localparam int MAX_OUT = 4;
    localparam int ID_W    = 4;
    localparam int CNT_W   = 3;

`ifdef FIR_XIFU_SB_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue_valid;
    logic [ID_W-1:0]  issue_id;
    logic             issue_accept;
    logic             issue_ready;
    logic             commit_valid;
    logic [ID_W-1:0]  commit_id;
    logic             commit_kill;
    logic [N_ID-1:0]  clear;
    logic [N_ID-1:0]  commit_vec;
    logic [N_ID-1:0]  kill_vec;
    logic [N_ID-1:0]  busy_vec;
    logic [CNT_W-1:0] outstanding;
    logic             err;

    fir_xifu_scoreboard #(.N_ID(N_ID), .MAX_OUT(MAX_OUT)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .issue_valid_i  (issue_valid),
        .issue_id_i     (issue_id),
        .issue_accept_i (issue_accept),
        .issue_ready_o  (issue_ready),
        .commit_valid_i (commit_valid),
        .commit_id_i    (commit_id),
        .commit_kill_i  (commit_kill),
        .clear_i        (clear),
        .commit_o       (commit_vec),
        .kill_o         (kill_vec),
        .busy_o         (busy_vec),
        .outstanding_o  (outstanding),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_ID-1:0]  c;
        logic [N_ID-1:0]  k;
        logic [N_ID-1:0]  b;
        logic [CNT_W-1:0] o;
        logic             e;
    } exp_t;

    exp_t stateQ[$];
    logic readyQ[$];
    int   testsRun  = 0;
    int   failCount = 0;

    // Reference model: which IDs are in flight, which are decided, and how.
    bit mLive[N_ID];
    bit mDecided[N_ID];
    bit mKilled[N_ID];
    bit mErr;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int liveCount();
        int n = 0;
        for (int i = 0; i < N_ID; i++) if (mLive[i]) n++;
        return n;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N_ID; i++) begin
            mLive[i]    = 1'b0;
            mDecided[i] = 1'b0;
            mKilled[i]  = 1'b0;
        end
        mErr = 1'b0;
    endtask

    task automatic applyStimulus(input bit iv, input int id, input bit acc,
                                 input bit cv, input int cid, input bit ck,
                                 input logic [N_ID-1:0] clr);
        bit   rdy;
        bit   fire;
        bit   bad;
        bit   nLive[N_ID];
        bit   nDec[N_ID];
        bit   nKill[N_ID];
        exp_t e;
        @(negedge clk);
        issue_valid  = iv;
        issue_id     = ID_W'(id);
        issue_accept = acc;
        commit_valid = cv;
        commit_id    = ID_W'(cid);
        commit_kill  = ck;
        clear        = clr;

        rdy  = (liveCount() < MAX_OUT) && !mLive[id];
        fire = iv && acc && rdy;
        bad  = iv && acc && !rdy;
        nLive = mLive;
        nDec  = mDecided;
        nKill = mKilled;
        if (fire) begin
            nLive[id] = 1'b1;
            nDec[id]  = 1'b0;
            nKill[id] = 1'b0;
        end
        if (cv) begin
            if ((fire && cid == id) || (mLive[cid] && !mDecided[cid])) begin
                nDec[cid]  = 1'b1;
                nKill[cid] = ck;
            end else begin
                bad = 1'b1;
            end
        end
        for (int k = 0; k < N_ID; k++) begin
            if (clr[k]) begin
                if (mLive[k] && mDecided[k]) nLive[k] = 1'b0;
                else bad = 1'b1;
            end
        end
        mLive    = nLive;
        mDecided = nDec;
        mKilled  = nKill;
        mErr     = mErr | bad;

        for (int k = 0; k < N_ID; k++) begin
            e.c[k] = mLive[k] && mDecided[k] && !mKilled[k];
            e.k[k] = mLive[k] && mDecided[k] && mKilled[k];
            e.b[k] = mLive[k];
        end
        e.o = CNT_W'(liveCount());
        e.e = ERR_ON && mErr;
        readyQ.push_back(rdy);
        stateQ.push_back(e);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, '0);
    endtask

    // Commit every pending ID, then release everything in flight.
    task automatic drain();
        logic [N_ID-1:0] m;
        for (int i = 0; i < N_ID; i++) begin
            if (mLive[i] && !mDecided[i]) applyStimulus(0, 0, 0, 1, i, 0, '0);
        end
        m = '0;
        for (int i = 0; i < N_ID; i++) m[i] = mLive[i];
        applyStimulus(0, 0, 0, 0, 0, 0, m);
        idle();
    endtask

    // Combinational ready check, shortly after the driver's negedge update.
    initial begin : monReady
        logic r;
        forever begin
            @(negedge clk);
            #1;
            if (readyQ.size() > 0) begin
                r = readyQ.pop_front();
                checkOutput("issue_ready", 32'(issue_ready), 32'(r));
            end
        end
    end

    // Registered outputs, one cycle after the stimulus that produced them.
    initial begin : monState
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (stateQ.size() > 0) begin
                x = stateQ.pop_front();
                checkOutput("commit_o", 32'(commit_vec), 32'(x.c));
                checkOutput("kill_o", 32'(kill_vec), 32'(x.k));
                checkOutput("busy_o", 32'(busy_vec), 32'(x.b));
                checkOutput("outstanding_o", 32'(outstanding), 32'(x.o));
                checkOutput("err_o", 32'(err), 32'(x.e));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin : driver
        bit              iv, acc, cv, ck;
        int              id, cid;
        logic [N_ID-1:0] clr;
        int              cands[$];

        issue_valid = 0; issue_id = '0; issue_accept = 0;
        commit_valid = 0; commit_id = '0; commit_kill = 0; clear = '0;
        modelReset();
        #2;
        checkOutput("reset_commit", 32'(commit_vec), 0);
        checkOutput("reset_kill", 32'(kill_vec), 0);
        checkOutput("reset_busy", 32'(busy_vec), 0);
        checkOutput("reset_outstanding", 32'(outstanding), 0);
        checkOutput("reset_err", 32'(err), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Basic flow on ID 3.
        applyStimulus(1, 3, 1, 0, 0, 0, '0);
        applyStimulus(0, 0, 0, 1, 3, 0, '0);
        idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0008);
        idle();

        // Duplicate commits on ID 5.
        applyStimulus(1, 5, 1, 0, 0, 0, '0);
        repeat (3) applyStimulus(0, 0, 0, 1, 5, 0, '0);
        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0020);
        idle();

        // Kill on ID 2.
        applyStimulus(1, 2, 1, 0, 0, 0, '0);
        applyStimulus(0, 0, 0, 1, 2, 1, '0);
        idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 16'h0004);
        idle();

        // Full: four outstanding blocks ID 4; clearing ID 1 frees a slot next cycle.
        for (int i = 0; i < 4; i++) applyStimulus(1, i, 1, 0, 0, 0, '0);
        applyStimulus(0, 0, 0, 1, 1, 0, '0);
        applyStimulus(1, 4, 1, 0, 0, 0, 16'h0002);
        applyStimulus(1, 4, 1, 0, 0, 0, '0);
        drain();

        // Same-cycle issue and commit of ID 7.
        applyStimulus(1, 7, 1, 1, 7, 0, '0);
        idle();
        drain();

        // Asynchronous reset with three IDs outstanding.
        for (int i = 1; i < 4; i++) applyStimulus(1, i, 1, 0, 0, 0, '0);
        @(posedge clk);
        #2;
        issue_valid = 0; issue_accept = 0; commit_valid = 0; commit_kill = 0; clear = '0;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_commit", 32'(commit_vec), 0);
        checkOutput("async_reset_kill", 32'(kill_vec), 0);
        checkOutput("async_reset_busy", 32'(busy_vec), 0);
        checkOutput("async_reset_outstanding", 32'(outstanding), 0);
        checkOutput("async_reset_err", 32'(err), 0);
        modelReset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        applyStimulus(1, 0, 1, 0, 0, 0, '0);
        idle();
        drain();

        // Randomized traffic, biased toward legal commits and clears.
        for (int n = 0; n < 600; n++) begin
            iv  = ($urandom_range(0, 99) < 60);
            id  = $urandom_range(0, N_ID - 1);
            acc = ($urandom_range(0, 9) != 0);
            cv  = ($urandom_range(0, 99) < 50);
            cid = $urandom_range(0, N_ID - 1);
            ck  = ($urandom_range(0, 3) == 0);
            cands.delete();
            for (int i = 0; i < N_ID; i++) if (mLive[i] && !mDecided[i]) cands.push_back(i);
            if (cands.size() > 0 && $urandom_range(0, 3) != 0)
                cid = cands[$urandom_range(0, cands.size() - 1)];
            clr = '0;
            for (int k = 0; k < N_ID; k++)
                if (mLive[k] && mDecided[k] && $urandom_range(0, 2) == 0) clr[k] = 1'b1;
            if ($urandom_range(0, 19) == 0) clr[$urandom_range(0, N_ID - 1)] = 1'b1;
            applyStimulus(iv, id, acc, cv, cid, ck, clr);
        end
        idle();

        repeat (3) @(posedge clk);
        #2;
        checkOutput("queue_drain", 32'(stateQ.size() + readyQ.size()), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
